// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types for the SPI transfer arbiter: FSM encoding, timeout counter width
// and SPI_CR1 enable-bit positions.
package spi_xfer_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_START    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_BUSY     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int TMO_W     = 16;
    localparam int CR1_SPE   = 7;
    localparam int CR1_MTSR  = 6;

    // Arbiter runs only while the SPI block is enabled and configured as master.
    function automatic logic cr1_enable(input logic [7:0] cr1);
        return cr1[CR1_SPE] && cr1[CR1_MTSR];
    endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side and spi_master-side signals of the transfer arbiter.
// slave = arbiter view, master = requesters plus spi_master view.
interface spi_xfer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = 8
);
    logic                      enable_in;
    logic [NUM_REQ-1:0]        req_in;
    logic [NUM_REQ*DATA_W-1:0] tx_data_in;
    logic [NUM_REQ-1:0]        gnt_out;
    logic [NUM_REQ-1:0]        done_out;
    logic [DATA_W-1:0]         rx_data_out;
    logic                      err_out;
    logic [IDX_W-1:0]          err_id_out;
    logic                      busy_out;
    logic [IDX_W-1:0]          cs_sel_out;
    logic                      m_new_tx_out;
    logic [DATA_W-1:0]         m_tx_data_out;
    logic                      m_finished_in;
    logic [DATA_W-1:0]         m_rx_data_in;

    modport slave (
        input  enable_in, req_in, tx_data_in, m_finished_in, m_rx_data_in,
        output gnt_out, done_out, rx_data_out, err_out, err_id_out, busy_out,
               cs_sel_out, m_new_tx_out, m_tx_data_out
    );

    modport master (
        output enable_in, req_in, tx_data_in, m_finished_in, m_rx_data_in,
        input  gnt_out, done_out, rx_data_out, err_out, err_id_out, busy_out,
               cs_sel_out, m_new_tx_out, m_tx_data_out
    );

endinterface

// File: rtl/spi_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module spi_xfer_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);
    int               w_k;
    logic [IDX_W-1:0] w_kidx;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = 0;
        w_kidx  = '0;
        // Scan farthest offset first so the nearest requester overwrites it.
        for (int off = N - 1; off >= 0; off--) begin
            w_k = int'(i_ptr) + off;
            if (w_k >= N) w_k = w_k - N;
            w_kidx = IDX_W'(w_k);
            if (i_req[w_kidx]) begin
                o_idx   = w_kidx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine between NUM_REQ requesters.
// Abort on timeout or enable drop; done_out and m_new_tx_out decode from the state.
module spi_xfer_arbiter
    import spi_xfer_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_in,
    input  logic              rst_in,
    spi_xfer_arbiter_if.slave bus
);
    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, r_idx, r_cs_sel, r_err_id, w_pick_idx, w_idx_inc;
    logic               w_pick_valid, w_abort, w_tmo_hit, r_err, r_busy;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [DATA_W-1:0]  r_rx, r_m_tx, w_tx_sel;

    spi_xfer_arbiter_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .i_req   (bus.req_in),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign w_idx_inc = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_tx_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_pick_idx == IDX_W'(i)) w_tx_sel = bus.tx_data_in[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE:     if (bus.enable_in && w_pick_valid) w_state_nxt = S_GRANT;
            S_GRANT:    if (!bus.enable_in) w_abort = 1'b1; else w_state_nxt = S_START;
            S_START:    if (!bus.enable_in) w_abort = 1'b1; else w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!bus.enable_in)          w_abort = 1'b1;
                else if (!bus.m_finished_in) w_state_nxt = S_BUSY;
                else if (w_tmo_hit)          w_abort = 1'b1;
            end
            S_BUSY: begin
                if (!bus.enable_in)         w_abort = 1'b1;
                else if (bus.m_finished_in) w_state_nxt = S_DONE;
                else if (w_tmo_hit)         w_abort = 1'b1;
            end
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cs_sel  <= '0;
            r_err_id  <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo_cnt <= '0;
            r_gnt     <= '0;
            r_rx      <= '0;
            r_m_tx    <= '0;
        end else begin
            r_err  <= 1'b0;
            r_busy <= (w_state_nxt != S_IDLE);
            if (r_state == S_START)
                r_tmo_cnt <= '0;
            else if (r_state == S_WAIT_ACK || r_state == S_BUSY)
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (r_state == S_IDLE && w_state_nxt == S_GRANT) begin
                r_idx    <= w_pick_idx;
                r_cs_sel <= w_pick_idx;
                r_gnt    <= NUM_REQ'(1) << w_pick_idx;
                r_m_tx   <= w_tx_sel;
            end
            if (r_state == S_BUSY && w_state_nxt == S_DONE)
                r_rx <= bus.m_rx_data_in;
            if (w_abort) begin
                r_err    <= 1'b1;
                r_err_id <= r_idx;
                r_gnt    <= '0;
                r_ptr    <= w_idx_inc;
            end
            if (r_state == S_DONE) begin
                r_gnt <= '0;
                r_ptr <= w_idx_inc;
            end
        end
    end

    assign bus.gnt_out       = r_gnt;
    assign bus.done_out      = (r_state == S_DONE) ? r_gnt : '0;
    assign bus.rx_data_out   = r_rx;
    assign bus.err_out       = r_err;
    assign bus.err_id_out    = r_err_id;
    assign bus.busy_out      = r_busy;
    assign bus.cs_sel_out    = r_cs_sel;
    assign bus.m_new_tx_out  = (r_state == S_START);
    assign bus.m_tx_data_out = r_m_tx;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a simple spi_master model that drops
// finished after each start pulse and raises it m_lat cycles later.
module tb_spi_xfer_arbiter;
    import spi_xfer_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_arbiter_if #(.NUM_REQ(4), .IDX_W(2), .DATA_W(8)) bus ();

    spi_xfer_arbiter #(.NUM_REQ(4), .IDX_W(2), .DATA_W(8), .TIMEOUT_CYC(1024)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    int         n_vec    = 0;
    int         n_fail   = 0;
    int         n_new_tx = 0;
    int         n_done   = 0;
    int         n_err    = 0;
    int         m_lat    = 3;
    logic       m_hang   = 1'b0;
    logic [7:0] m_rx_val = 8'h00;
    logic [3:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.done_out != 4'b0000);
        end
        check({tag, " seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        bus.m_finished_in = 1'b1;
        bus.m_rx_data_in  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.m_new_tx_out) begin
                bus.m_finished_in = 1'b0;
                repeat (m_lat) @(negedge clk);
                while (m_hang) @(negedge clk);
                bus.m_rx_data_in  = m_rx_val;
                bus.m_finished_in = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.m_new_tx_out) n_new_tx++;
        if (bus.done_out != 4'b0000) n_done++;
        if (bus.err_out) n_err++;
    end

    initial begin
        int  cyc;
        logic got_err, got_done, got_tx;
        bus.enable_in  = cr1_enable(8'hC0);
        bus.req_in     = 4'b0000;
        bus.tx_data_in = {8'h9D, 8'hA5, 8'h4B, 8'h17};
        tick(3);
        check("rst gnt",    32'(bus.gnt_out),       32'h0);
        check("rst done",   32'(bus.done_out),      32'h0);
        check("rst busy",   32'(bus.busy_out),      32'h0);
        check("rst new_tx", 32'(bus.m_new_tx_out),  32'h0);
        check("rst m_tx",   32'(bus.m_tx_data_out), 32'h0);
        check("rst err",    32'(bus.err_out),       32'h0);
        rst = 1'b0;
        tick(2);

        // all four requesting from ptr 0: 0,1,2,3,0
        m_rx_val   = 8'h5A;
        bus.req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr1111 done");
            check("rr1111 order", 32'(bus.done_out), 32'(exp_rr[k]));
            check("rr1111 gnt",   32'(bus.gnt_out),  32'(exp_rr[k]));
            if (k == 4) bus.req_in = 4'b0000;
        end
        tick(1);
        check("rr1111 idle gap", 32'(bus.busy_out),    32'h0);
        check("rr1111 rx",       32'(bus.rx_data_out), 32'h5A);

        // ptr now 1: 3 wins, then wrap back to 0
        bus.req_in = 4'b1001;
        wait_done("wrap done a");
        check("wrap first 3", 32'(bus.done_out), 32'b1000);
        wait_done("wrap done b");
        check("wrap then 0", 32'(bus.done_out), 32'b0001);
        bus.req_in = 4'b0000;
        tick(1);

        // single requester 2, req and tx changed right after grant
        m_rx_val   = 8'h3C;
        bus.req_in = 4'b0100;
        tick(1);
        check("single gnt",    32'(bus.gnt_out),       32'b0100);
        check("single cs",     32'(bus.cs_sel_out),    32'd2);
        check("single busy",   32'(bus.busy_out),      32'd1);
        check("single no tx",  32'(bus.m_new_tx_out),  32'd0);
        check("single m_tx g", 32'(bus.m_tx_data_out), 32'hA5);
        bus.req_in     = 4'b0000;
        bus.tx_data_in = {8'h9D, 8'h11, 8'h4B, 8'h17};
        tick(1);
        check("single new_tx", 32'(bus.m_new_tx_out),  32'd1);
        check("single m_tx s", 32'(bus.m_tx_data_out), 32'hA5);
        wait_done("single done");
        check("single done2",  32'(bus.done_out),    32'b0100);
        check("single rx",     32'(bus.rx_data_out), 32'h3C);
        check("single gnt dn", 32'(bus.gnt_out),     32'b0100);
        tick(1);
        check("single done off", 32'(bus.done_out), 32'h0);
        check("single gnt off",  32'(bus.gnt_out),  32'h0);
        check("single idle",     32'(bus.busy_out), 32'h0);

        // master never finishes: START cycle + 1024 wait cycles -> err visible 1025 cycles after start
        m_hang     = 1'b1;
        bus.req_in = 4'b0010;
        tick(1);
        bus.req_in = 4'b0000;
        got_tx = 1'b0;
        for (int i = 0; i < 10 && !got_tx; i++) begin
            @(negedge clk);
            got_tx = bus.m_new_tx_out;
        end
        check("tmo start seen", 32'(got_tx), 32'd1);
        cyc = 0; got_err = 1'b0; got_done = 1'b0;
        for (int i = 0; i < 1100 && !got_err; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.done_out != 4'b0000) got_done = 1'b1;
            got_err = bus.err_out;
        end
        check("tmo err",    32'(got_err),        32'd1);
        check("tmo cycles", 32'(cyc),            32'd1025);
        check("tmo id",     32'(bus.err_id_out), 32'd1);
        check("tmo gnt",    32'(bus.gnt_out),    32'h0);
        check("tmo busy",   32'(bus.busy_out),   32'h0);
        check("tmo nodone", 32'(got_done),       32'd0);
        tick(1);
        check("tmo err pulse", 32'(bus.err_out), 32'd0);
        m_hang = 1'b0;
        tick(2);
        m_rx_val   = 8'hE1;
        bus.req_in = 4'b0001;
        wait_done("post tmo done");
        check("post tmo who", 32'(bus.done_out),    32'b0001);
        check("post tmo rx",  32'(bus.rx_data_out), 32'hE1);
        bus.req_in = 4'b0000;
        tick(1);

        // enable dropped in BUSY
        m_lat      = 10;
        m_rx_val   = 8'h66;
        bus.req_in = 4'b1000;
        tick(4);
        check("dis gnt",  32'(bus.gnt_out),  32'b1000);
        check("dis busy", 32'(bus.busy_out), 32'd1);
        bus.enable_in = cr1_enable(8'h80);
        tick(1);
        check("dis err",    32'(bus.err_out),     32'd1);
        check("dis id",     32'(bus.err_id_out),  32'd3);
        check("dis gnt0",   32'(bus.gnt_out),     32'h0);
        check("dis busy0",  32'(bus.busy_out),    32'h0);
        check("dis nodone", 32'(bus.done_out),    32'h0);
        check("dis rx",     32'(bus.rx_data_out), 32'hE1);
        bus.req_in = 4'b0001;
        tick(5);
        check("dis no grant", 32'(bus.gnt_out),  32'h0);
        check("dis no busy",  32'(bus.busy_out), 32'h0);
        bus.req_in    = 4'b0000;
        bus.enable_in = cr1_enable(8'hC0);
        tick(12);
        m_lat      = 3;
        m_rx_val   = 8'hC7;
        bus.req_in = 4'b0001;
        wait_done("reen done");
        check("reen who", 32'(bus.done_out),    32'b0001);
        check("reen rx",  32'(bus.rx_data_out), 32'hC7);
        bus.req_in = 4'b0000;
        tick(1);

        // reset during BUSY with ptr = 1
        m_lat      = 10;
        bus.req_in = 4'b0100;
        tick(4);
        check("mrst busy pre", 32'(bus.busy_out), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mrst gnt",    32'(bus.gnt_out),       32'h0);
        check("mrst busy",   32'(bus.busy_out),      32'h0);
        check("mrst cs",     32'(bus.cs_sel_out),    32'h0);
        check("mrst m_tx",   32'(bus.m_tx_data_out), 32'h0);
        check("mrst rx",     32'(bus.rx_data_out),   32'h0);
        check("mrst err_id", 32'(bus.err_id_out),    32'h0);
        check("mrst new_tx", 32'(bus.m_new_tx_out),  32'h0);
        bus.req_in = 4'b0000;
        tick(2);
        rst = 1'b0;
        tick(12);
        m_lat      = 3;
        m_rx_val   = 8'h99;
        bus.req_in = 4'b1111;
        wait_done("mrst first done");
        check("mrst first is 0", 32'(bus.done_out),    32'b0001);
        check("mrst rx",         32'(bus.rx_data_out), 32'h99);
        bus.req_in = 4'b0000;
        tick(3);

        check("total new_tx", 32'(n_new_tx), 32'd14);
        check("total done",   32'(n_done),   32'd11);
        check("total err",    32'(n_err),    32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
